// File: rtl/pwm_freq_gen_pkg.sv
// Shared types and widths for the PWM frequency generator.
// The high-time helper is the single place where the duty scaling lives.
package pwm_freq_gen_pkg;

    localparam int DIV_W     = 7;
    localparam int DUTY_W    = 5;
    localparam int DUTY_FULL = 16;
    localparam int PROD_W    = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty);
        return (duty > DUTY_W'(DUTY_FULL)) ? DUTY_W'(DUTY_FULL) : duty;
    endfunction

    // (div * duty) / 16, formed at 11 bits; 127 * 16 >> 4 still fits 7 bits.
    function automatic logic [DIV_W-1:0] calc_high(input logic [DIV_W-1:0]  div,
                                                   input logic [DUTY_W-1:0] duty);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(div) * PROD_W'(duty);
        return DIV_W'(prod >> 4);
    endfunction

endpackage

// File: rtl/pwm_freq_gen_tick_gen.sv
// Free-running prescaler: tick is high for one clk out of every PRESC.
module tick_gen #(
    parameter int PRESC = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(PRESC);
    localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

    logic [CW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = (pre_q == LAST) ? '0 : pre_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
    end

    assign tick = (pre_q == LAST);

endmodule

// File: rtl/pwm_freq_gen.sv
// PWM generator with boundary-only shadow reload: div/duty are latched at the
// start of each period so mid-period input changes never produce short pulses.
module pwm_freq_gen
    import pwm_freq_gen_pkg::*;
#(
    parameter int PRESC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_in,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              pwm_out,
    output logic              period_start,
    output logic              busy
);

    logic tick;

    tick_gen #(.PRESC(PRESC)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_s_q, div_s_d;
    logic [DIV_W-1:0]  high_s_q, high_s_d;
    logic [DUTY_W-1:0] duty_s_q, duty_s_d;
    logic              pwm_q, pwm_d;
    logic              ps_q, ps_d;

    logic [DUTY_W-1:0] duty_clamped;
    logic [DIV_W-1:0]  high_calc;
    logic              load_ok;
    logic              do_load;

    assign duty_clamped = clamp_duty(duty_in);
    assign high_calc    = calc_high(div_in, duty_clamped);
    assign load_ok      = en && (div_in != '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_s_d  = div_s_q;
        high_s_d = high_s_q;
        duty_s_d = duty_s_q;
        ps_d     = 1'b0;
        do_load  = 1'b0;
        // Full duty is forced high so the last count of a period never dips.
        pwm_d    = (state_q == ST_RUN) &&
                   ((duty_s_q == DUTY_W'(DUTY_FULL)) || (cnt_q < high_s_q));

        if (tick) begin
            unique case (state_q)
                ST_IDLE: do_load = load_ok;
                ST_RUN: begin
                    if (cnt_q < div_s_q - DIV_W'(1)) begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (load_ok) do_load = 1'b1;
                        else         state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (do_load) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            div_s_d  = div_in;
            duty_s_d = duty_clamped;
            high_s_d = high_calc;
            ps_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_s_q  <= '0;
            high_s_q <= '0;
            duty_s_q <= '0;
            pwm_q    <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_s_q  <= div_s_d;
            high_s_q <= high_s_d;
            duty_s_q <= duty_s_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign busy         = (state_q == ST_RUN);

endmodule
